// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer_if
// Description : Bundles the store buffer's core-side store/load channel and
//               its data-memory channel.
//               master : core/memory side (drives stores, loads, dmem_rd)
//               slave  : store buffer (drives ready, forwarding, dmem writes)
//   st_valid/st_addr/st_data/st_ready : store push handshake
//   drain_en                          : permits draining to memory
//   ld_addr/ld_data                   : load address and forwarded result
//   dmem_rd/dmem_ra                   : memory read data / read address
//   dmem_we/dmem_a/dmem_wd            : memory write port (head entry)
//   sb_empty/sb_count                 : occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int PW    = 2
);
    logic          st_valid;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic          st_ready;
    logic          drain_en;
    logic [31:0]   ld_addr;
    logic [31:0]   ld_data;
    logic [31:0]   dmem_rd;
    logic          dmem_we;
    logic [31:0]   dmem_a;
    logic [31:0]   dmem_wd;
    logic [31:0]   dmem_ra;
    logic          sb_empty;
    logic [PW:0]   sb_count;

    modport master (
        output st_valid, st_addr, st_data, drain_en, ld_addr, dmem_rd,
        input  st_ready, ld_data, dmem_we, dmem_a, dmem_wd, dmem_ra,
               sb_empty, sb_count
    );

    modport slave (
        input  st_valid, st_addr, st_data, drain_en, ld_addr, dmem_rd,
        output st_ready, ld_data, dmem_we, dmem_a, dmem_wd, dmem_ra,
               sb_empty, sb_count
    );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Posted-write FIFO between the core memory stage and the
//               word-addressed data memory. Stores are accepted in one cycle
//               and drained one per cycle in program order; loads see the
//               youngest buffered store to the same word.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - store_buffer_if.slave (store, load, dmem, status)
// Parameters  : DEPTH - number of entries (power of two, 2..16)
//               PW    - pointer width, log2(DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    store_buffer_if.slave    bus
);

    localparam logic [PW:0]   c_FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] c_PTR_ONE  = PW'(1);

    // Pointer and occupancy state
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    // Entry storage; never reset, validity comes from r_count
    logic [29:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];

    logic          w_push;
    logic          w_pop;
    logic          w_ready;

    // Per-age forwarding view: index 0 is the head (oldest)
    logic [DEPTH-1:0] w_hit;
    logic [31:0]      w_age_data [DEPTH];
    logic [31:0]      w_ld_data;

    // Only the word part of the byte addresses matters
    logic w_unused;
    assign w_unused = &{1'b0, bus.st_addr[1:0], bus.ld_addr[1:0]};

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    assign w_ready = (r_count != c_FULL_CNT);
    assign w_push  = bus.st_valid && w_ready;
    // Draining is gated by the registered count only, so a store pushed
    // this cycle cannot fall through to memory in the same cycle.
    assign w_pop   = (r_count != '0) && bus.drain_en;

    assign bus.st_ready = w_ready;
    assign bus.sb_empty = (r_count == '0);
    assign bus.sb_count = r_count;

    // ------------------------------------------------------------------
    // Memory write port: always presents the head entry
    // ------------------------------------------------------------------
    assign bus.dmem_we = w_pop;
    assign bus.dmem_a  = {r_addr[r_head], 2'b00};
    assign bus.dmem_wd = r_data[r_head];
    assign bus.dmem_ra = bus.ld_addr;

    // ------------------------------------------------------------------
    // Pointer / count registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry write at the tail
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= bus.st_addr[31:2];
            r_data[r_tail] <= bus.st_data;
        end
    end

    // ------------------------------------------------------------------
    // Load forwarding. Entries are examined in age order starting at the
    // head, so the comparison is independent of where the pointers sit in
    // the physical array and stays correct across the wrap.
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_age
            localparam logic [PW-1:0] c_OFF = PW'(g);
            localparam logic [PW:0]   c_AGE = (PW+1)'(g);
            logic [PW-1:0] w_idx;
            assign w_idx         = r_head + c_OFF;
            assign w_hit[g]      = (c_AGE < r_count) &&
                                   (r_addr[w_idx] == bus.ld_addr[31:2]);
            assign w_age_data[g] = r_data[w_idx];
        end
    endgenerate

    // Later (younger) hits override earlier ones
    always_comb begin
        w_ld_data = bus.dmem_rd;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_hit[i]) begin
                w_ld_data = w_age_data[i];
            end
        end
    end

    assign bus.ld_data = w_ld_data;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer. A queue-based model
//               tracks pending stores in program order; a compare process
//               checks every DUT output against it each cycle, and directed
//               sequences pin the model with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int PW    = 2;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } entry_t;

    logic clk;
    logic rst_n;

    store_buffer_if #(.DEPTH(DEPTH), .PW(PW)) sbif ();

    store_buffer #(.DEPTH(DEPTH), .PW(PW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbif.slave)
    );

    int checks   = 0;
    int failures = 0;

    entry_t      q[$];      // pending stores, oldest first
    logic [31:0] wlog[$];   // addresses written to memory, in order

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_ld(input logic [31:0] addr,
                                             input logic [31:0] rd);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == addr[31:2]) return q[i].d;
        end
        return rd;
    endfunction

    // Reference model: what the buffer holds after each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            automatic bit do_push = sbif.st_valid && (q.size() != DEPTH);
            automatic bit do_pop  = sbif.drain_en && (q.size() != 0);
            automatic entry_t e;
            if (do_pop) begin
                wlog.push_back({q[0].a, 2'b00});
                void'(q.pop_front());
            end
            if (do_push) begin
                e.a = sbif.st_addr[31:2];
                e.d = sbif.st_data;
                q.push_back(e);
            end
        end
    end

    // Compare process: outputs are settled by the falling edge
    always @(negedge clk) begin
        chk("st_ready", {31'd0, sbif.st_ready}, {31'd0, q.size() != DEPTH});
        chk("sb_empty", {31'd0, sbif.sb_empty}, {31'd0, q.size() == 0});
        chk("sb_count", {29'd0, sbif.sb_count}, 32'(q.size()));
        chk("dmem_we",  {31'd0, sbif.dmem_we},
            {31'd0, rst_n && sbif.drain_en && (q.size() != 0)});
        chk("dmem_ra",  sbif.dmem_ra, sbif.ld_addr);
        chk("ld_data",  sbif.ld_data, model_ld(sbif.ld_addr, sbif.dmem_rd));
        if (q.size() != 0) begin
            chk("dmem_a",  sbif.dmem_a,  {q[0].a, 2'b00});
            chk("dmem_wd", sbif.dmem_wd, q[0].d);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        sbif.st_valid = 1'b1;
        sbif.st_addr  = a;
        sbif.st_data  = d;
        step();
        sbif.st_valid = 1'b0;
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        sbif.st_valid = 1'b0;
        sbif.drain_en = 1'b1;
        while (!sbif.sb_empty && n < 40) begin
            step();
            n++;
        end
        chk("drain_timeout", {31'd0, sbif.sb_empty}, 32'd1);
    endtask

    initial begin
        int n_log;
        rst_n         = 1'b0;
        sbif.st_valid = 1'b0;
        sbif.st_addr  = '0;
        sbif.st_data  = '0;
        sbif.drain_en = 1'b0;
        sbif.ld_addr  = '0;
        sbif.dmem_rd  = '0;
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        // Idle after reset
        chk("rst_empty", {31'd0, sbif.sb_empty}, 32'd1);
        chk("rst_ready", {31'd0, sbif.st_ready}, 32'd1);
        chk("rst_we",    {31'd0, sbif.dmem_we},  32'd0);
        chk("rst_count", {29'd0, sbif.sb_count}, 32'd0);

        // Single store drains the next cycle
        sbif.drain_en = 1'b1;
        push(32'h10, 32'hAAAA0001);
        #1;
        chk("one_we", {31'd0, sbif.dmem_we}, 32'd1);
        chk("one_a",  sbif.dmem_a,  32'h10);
        chk("one_wd", sbif.dmem_wd, 32'hAAAA0001);
        step();
        chk("one_empty", {31'd0, sbif.sb_empty}, 32'd1);

        // Fill with draining held
        sbif.drain_en = 1'b0;
        push(32'h20, 32'd1);
        push(32'h24, 32'd2);
        push(32'h20, 32'd3);
        push(32'h28, 32'd4);
        #1;
        chk("full_count", {29'd0, sbif.sb_count}, 32'd4);
        chk("full_ready", {31'd0, sbif.st_ready}, 32'd0);
        sbif.ld_addr = 32'h20;
        #1;
        chk("fwd_young", sbif.ld_data, 32'd3);
        sbif.ld_addr = 32'h2C;
        sbif.dmem_rd = 32'h55;
        #1;
        chk("fwd_miss", sbif.ld_data, 32'h55);
        push(32'h30, 32'd5);
        chk("fifth_ignored", {29'd0, sbif.sb_count}, 32'd4);

        // Drain from full while the core keeps offering a store
        wlog.delete();
        sbif.drain_en = 1'b1;
        sbif.st_valid = 1'b1;
        sbif.st_addr  = 32'h30;
        sbif.st_data  = 32'd5;
        step();
        chk("no_push_full", {29'd0, sbif.sb_count}, 32'd3);
        step();
        chk("push_after", {29'd0, sbif.sb_count}, 32'd3);
        drain_all();
        chk("order_n", 32'(wlog.size()), 32'd5);
        if (wlog.size() == 5) begin
            chk("order0", wlog[0], 32'h20);
            chk("order1", wlog[1], 32'h24);
            chk("order2", wlog[2], 32'h20);
            chk("order3", wlog[3], 32'h28);
            chk("order4", wlog[4], 32'h30);
        end

        // Six pushes so far: these three occupy slots 2, 3, 0 (wrapped)
        sbif.drain_en = 1'b0;
        push(32'h50, 32'd1);
        push(32'h54, 32'd2);
        push(32'h50, 32'd3);
        sbif.ld_addr = 32'h50;
        #1;
        chk("wrap_fwd", sbif.ld_data, 32'd3);
        chk("wrap_count", {29'd0, sbif.sb_count}, 32'd3);

        // Asynchronous reset mid-cycle with three stores pending
        n_log         = wlog.size();
        sbif.drain_en = 1'b1;
        rst_n         = 1'b0;
        #1;
        chk("arst_count", {29'd0, sbif.sb_count}, 32'd0);
        chk("arst_we",    {31'd0, sbif.dmem_we},  32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("arst_nowrite", 32'(wlog.size()), 32'(n_log));

        // Randomized traffic over a small address set
        for (int i = 0; i < 400; i++) begin
            sbif.st_valid = ($urandom_range(0, 3) != 0);
            sbif.st_addr  = 32'h40 + 32'($urandom_range(0, 3) * 4) +
                            32'($urandom_range(0, 3));
            sbif.st_data  = $urandom;
            sbif.drain_en = ($urandom_range(0, 2) != 0);
            sbif.ld_addr  = 32'h40 + 32'($urandom_range(0, 4) * 4);
            sbif.dmem_rd  = $urandom;
            step();
        end
        drain_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
